// File: rtl/flag_update_unit.sv
// Condition-flag producer: queues masks of in-flight flag-writing ALU ops, retires them in order into N/Z/C.
// Latency: flags update 1 cycle after result_valid; flags_pending/issue_ready follow registered count; stall is combinational.
// Backpressure: issue_ready low when PEND_DEPTH ops are outstanding; issues while full are dropped, not queued.
module flag_update_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int PEND_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [2:0]            issue_mask,
    output logic                  issue_ready,
    input  logic                  result_valid,
    input  logic [DATA_WIDTH-1:0] result_value,
    input  logic                  result_carry,
    input  logic                  branch_conditional,
    output logic                  negative,
    output logic                  zero,
    output logic                  carry,
    output logic                  flags_pending,
    output logic                  stall,
    output logic                  protocol_error
);

    localparam int PW = $clog2(PEND_DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]    mask_mem [PEND_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [2:0]    pop_mask;

    assign issue_ready   = (count < CW'(PEND_DEPTH));
    assign flags_pending = (count != '0);
    assign stall         = branch_conditional & flags_pending;

    // Pop qualification uses the registered count, so a same-cycle issue is never consumed.
    assign push     = issue_valid & issue_ready;
    assign pop      = result_valid & flags_pending;
    assign pop_mask = mask_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PEND_DEPTH; i++) begin
                mask_mem[i] <= '0;
            end
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            negative       <= 1'b0;
            zero           <= 1'b0;
            carry          <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            if (push) begin
                mask_mem[wr_ptr] <= issue_mask;
                wr_ptr           <= wr_ptr + PW'(1);
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (pop_mask[2]) negative <= result_value[DATA_WIDTH-1];
                if (pop_mask[1]) zero     <= (result_value == '0);
                if (pop_mask[0]) carry    <= result_carry;
            end

            if (result_valid && !flags_pending) begin
                protocol_error <= 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
